// File: rtl/de_board_pkg.sv
// Shared DE-board definitions: segment encodings, mode/direction codes, key and
// switch indices, and the single-digit up/down step used by the counters.
package de_board_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low segments, bit6 = g ... bit0 = a; entry 0 is the rightmost.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  typedef enum logic {MODE_DEC = 1'b0, MODE_HEX = 1'b1} mode_e;
  typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} dir_e;

  localparam int KEY_RUN   = 1;
  localparam int KEY_CLEAR = 2;
  localparam int KEY_LOAD  = 3;
  localparam int SW_DIR    = 0;
  localparam int SW_MODE   = 1;

  // Returns {carry_or_borrow, new_digit}; decimal down treats 10..15 as plain decrements.
  function automatic logic [4:0] step_digit(input logic [3:0] d, input dir_e dir,
                                            input mode_e mode);
    logic [4:0] r;
    if (dir == DIR_UP) begin
      if (mode == MODE_HEX) r = (d == 4'hF) ? 5'h10 : {1'b0, d + 4'd1};
      else                  r = (d >= 4'd9) ? 5'h10 : {1'b0, d + 4'd1};
    end else begin
      if (d == 4'd0) r = (mode == MODE_HEX) ? 5'h1F : 5'h19;
      else           r = {1'b0, d - 4'd1};
    end
    return r;
  endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Combinational 0-F to active-low seven-segment decoder.
module seg7_decoder
  import de_board_pkg::*;
(
  input  logic [3:0] digit_i,
  output logic [6:0] seg_o
);

  assign seg_o = SEG_TABLE[digit_i];

endmodule

// File: rtl/hex_counter_display.sv
// N-digit decimal/hex up/down counter with run/clear/load keys, driving the
// DE-board HEX displays and LEDs through registered outputs.
module hex_counter_display
  import de_board_pkg::*;
#(
  parameter int DIGITS  = 6,
  parameter int CLK_HZ  = 50_000_000,
  parameter int TICK_HZ = 100
) (
  input  logic       CLOCK_50,
  input  logic       RESETn,
  input  logic [3:0] KEY,
  input  logic [9:0] SW,
  output logic [6:0] HEX0,
  output logic [6:0] HEX1,
  output logic [6:0] HEX2,
  output logic [6:0] HEX3,
  output logic [6:0] HEX4,
  output logic [6:0] HEX5,
  output logic [9:0] LEDR
);

  localparam int PRE_TC = CLK_HZ / TICK_HZ - 1;
  localparam int PW     = $clog2(PRE_TC + 1);
  localparam int CW     = DIGITS * 4;
  localparam logic [PW-1:0] PRE_TC_V = PW'(PRE_TC);

  logic [3:1] sync1_q, sync2_q, prev_q, press_q;
  logic [1:0] settle_q;

  // Edges are ignored until the synchroniser holds real samples, so a key held
  // through reset release does not look like a fresh press.
  always_ff @(posedge CLOCK_50) begin
    if (!RESETn) begin
      sync1_q  <= '1;
      sync2_q  <= '1;
      prev_q   <= '1;
      press_q  <= '0;
      settle_q <= '0;
    end else begin
      sync1_q <= KEY[3:1];
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      press_q <= (settle_q == 2'd3) ? (prev_q & ~sync2_q) : '0;
      if (settle_q != 2'd3) settle_q <= settle_q + 2'd1;
    end
  end

  logic run_p, clr_p, load_p;
  assign run_p  = press_q[KEY_RUN];
  assign clr_p  = press_q[KEY_CLEAR];
  assign load_p = press_q[KEY_LOAD];

  logic unused_key;
  assign unused_key = KEY[0];

  mode_e mode;
  dir_e  dir;
  assign mode = mode_e'(SW[SW_MODE]);
  assign dir  = dir_e'(SW[SW_DIR]);

  logic [PW-1:0] pre_q, pre_d;
  logic [CW-1:0] cnt_q, cnt_d, step_cnt, load_val;
  logic          running_q, running_d, wrap_q, wrap_d;
  logic          tick, carry;

  generate
    if (DIGITS > 1) begin : g_load_two
      assign load_val = CW'(SW[9:2]);
    end else begin : g_load_one
      assign load_val = SW[5:2];
    end
  endgenerate

  assign tick = running_q && (pre_q == PRE_TC_V);

  // Carry/borrow ripples through every digit in the same cycle.
  always_comb begin
    carry    = 1'b1;
    step_cnt = cnt_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) {carry, step_cnt[i*4 +: 4]} = step_digit(cnt_q[i*4 +: 4], dir, mode);
    end
  end

  always_comb begin
    running_d = running_q ^ run_p;
    pre_d     = pre_q;
    cnt_d     = cnt_q;
    wrap_d    = wrap_q;
    if (running_q) pre_d = tick ? '0 : pre_q + PW'(1);
    if (clr_p) begin
      cnt_d  = '0;
      pre_d  = '0;
      wrap_d = 1'b0;
    end else if (load_p) begin
      cnt_d  = load_val;
      pre_d  = '0;
      wrap_d = 1'b0;
    end else if (tick) begin
      cnt_d = step_cnt;
      if (carry) wrap_d = 1'b1;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (!RESETn) begin
      pre_q     <= '0;
      cnt_q     <= '0;
      running_q <= 1'b0;
      wrap_q    <= 1'b0;
    end else begin
      pre_q     <= pre_d;
      cnt_q     <= cnt_d;
      running_q <= running_d;
      wrap_q    <= wrap_d;
    end
  end

  logic [6:0] seg_d [6];
  logic [6:0] hex_q [6];
  logic [9:0] ledr_q;

  for (genvar g = 0; g < 6; g++) begin : g_dig
    if (g < DIGITS) begin : g_on
      seg7_decoder u_dec (
        .digit_i (cnt_q[g*4 +: 4]),
        .seg_o   (seg_d[g])
      );
    end else begin : g_off
      assign seg_d[g] = SEG_BLANK;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (!RESETn) begin
      for (int i = 0; i < 6; i++) hex_q[i] <= (i < DIGITS) ? SEG_TABLE[0] : SEG_BLANK;
      ledr_q <= '0;
    end else begin
      for (int i = 0; i < 6; i++) hex_q[i] <= seg_d[i];
      ledr_q <= {8'b0, wrap_q, running_q};
    end
  end

  assign HEX0 = hex_q[0];
  assign HEX1 = hex_q[1];
  assign HEX2 = hex_q[2];
  assign HEX3 = hex_q[3];
  assign HEX4 = hex_q[4];
  assign HEX5 = hex_q[5];
  assign LEDR = ledr_q;

endmodule

// File: tb/tb_hex_counter_display.sv
// Directed bench for hex_counter_display: a 3-digit and a 2-digit instance share
// inputs, with a tick every 10 clocks.
module tb_hex_counter_display;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [3:0] key;
  logic [9:0] sw;
  logic [6:0] a_hex0, a_hex1, a_hex2, a_hex3, a_hex4, a_hex5;
  logic [6:0] b_hex0, b_hex1, b_hex2, b_hex3, b_hex4, b_hex5;
  logic [9:0] a_ledr, b_ledr;

  hex_counter_display #(.DIGITS(3), .CLK_HZ(10), .TICK_HZ(1)) u_dut (
    .CLOCK_50 (clk), .RESETn (rst_n), .KEY (key), .SW (sw),
    .HEX0 (a_hex0), .HEX1 (a_hex1), .HEX2 (a_hex2),
    .HEX3 (a_hex3), .HEX4 (a_hex4), .HEX5 (a_hex5), .LEDR (a_ledr)
  );

  hex_counter_display #(.DIGITS(2), .CLK_HZ(10), .TICK_HZ(1)) u_dut2 (
    .CLOCK_50 (clk), .RESETn (rst_n), .KEY (key), .SW (sw),
    .HEX0 (b_hex0), .HEX1 (b_hex1), .HEX2 (b_hex2),
    .HEX3 (b_hex3), .HEX4 (b_hex4), .HEX5 (b_hex5), .LEDR (b_ledr)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;
  logic [20:0] exp_q[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_a(input string nm, input logic [6:0] e2, input logic [6:0] e1,
                       input logic [6:0] e0, input logic [9:0] el);
    check({nm, ".hex3"}, {a_hex2, a_hex1, a_hex0}, {e2, e1, e0});
    check({nm, ".ledr3"}, a_ledr, el);
  endtask

  task automatic chk_b(input string nm, input logic [6:0] e1, input logic [6:0] e0,
                       input logic [9:0] el);
    check({nm, ".hex2"}, {b_hex2, b_hex1, b_hex0}, {7'h7F, e1, e0});
    check({nm, ".ledr2"}, b_ledr, el);
  endtask

  // ---------------- drivers ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Pulls the masked keys low for one sampled edge, then releases them.
  task automatic press(input logic [3:0] mask);
    key = ~mask;
    @(negedge clk);
    key = 4'hF;
  endtask

  typedef struct {
    logic [7:0] ld;
    logic [6:0] h1;
    logic [6:0] h0;
  } vec_t;

  vec_t vecs[9];

  initial begin
    logic [20:0] e;

    vecs[0] = '{8'h00, 7'h40, 7'h40};
    vecs[1] = '{8'h12, 7'h79, 7'h24};
    vecs[2] = '{8'h9A, 7'h10, 7'h08};
    vecs[3] = '{8'h5F, 7'h12, 7'h0E};
    vecs[4] = '{8'hC3, 7'h46, 7'h30};
    vecs[5] = '{8'h7B, 7'h78, 7'h03};
    vecs[6] = '{8'hD6, 7'h21, 7'h02};
    vecs[7] = '{8'h84, 7'h00, 7'h19};
    vecs[8] = '{8'hE0, 7'h06, 7'h40};

    key   = 4'hF;
    sw    = '0;
    rst_n = 1'b0;
    cyc(2);
    chk_a("reset", 7'h40, 7'h40, 7'h40, 10'h000);
    check("reset.blank", {a_hex5, a_hex4, a_hex3}, {3{7'h7F}});
    chk_b("reset", 7'h40, 7'h40, 10'h000);
    check("reset.blank2", {b_hex5, b_hex4, b_hex3}, {3{7'h7F}});
    rst_n = 1'b1;
    cyc(5);

    // Load table: every glyph passes through the decoder.
    for (int i = 0; i < 9; i++) begin
      sw = {vecs[i].ld, 2'b00};
      exp_q.push_back({7'h40, vecs[i].h1, vecs[i].h0});
      press(4'b1000);
      cyc(4);
      e = exp_q.pop_front();
      check($sformatf("load%0d.hex3", i), {a_hex2, a_hex1, a_hex0}, e);
      check($sformatf("load%0d.hex2", i), {b_hex2, b_hex1, b_hex0}, {7'h7F, e[13:0]});
      check($sformatf("load%0d.ledr", i), a_ledr, 10'h000);
    end

    // Decimal up: run latency, tick spacing, decimal carry.
    press(4'b0100);
    cyc(4);
    sw = '0;
    press(4'b0010);
    cyc(3);
    check("run_early", a_ledr[0], 1'b0);
    cyc(1);
    check("run_led", a_ledr[0], 1'b1);
    cyc(90);
    check("nine_ticks", a_hex0, 7'h10);
    cyc(9);
    check("tick10_early", a_hex0, 7'h10);
    cyc(1);
    chk_a("ten_ticks", 7'h40, 7'h79, 7'h40, 10'h001);

    // Stop pulse lands on a tick cycle: tick counted, then hold.
    cyc(5);
    press(4'b0010);
    cyc(4);
    chk_a("stop_on_tick", 7'h40, 7'h79, 7'h79, 10'h000);
    cyc(30);
    chk_a("stop_hold", 7'h40, 7'h79, 7'h79, 10'h000);
    press(4'b0010);
    cyc(13);
    check("restart_early", a_hex0, 7'h79);
    cyc(1);
    chk_a("restart_tick", 7'h40, 7'h79, 7'h24, 10'h001);

    // Stop mid-count with the prescaler at 5, then resume from there.
    press(4'b0010);
    cyc(23);
    chk_a("mid_hold", 7'h40, 7'h79, 7'h24, 10'h000);
    press(4'b0010);
    cyc(8);
    check("resume_early", a_hex0, 7'h24);
    cyc(1);
    chk_a("resume_tick", 7'h40, 7'h79, 7'h30, 10'h001);
    press(4'b0010);
    cyc(4);

    // Load zero, decimal down, one tick wraps to 999.
    sw = 10'h001;
    press(4'b1000);
    cyc(4);
    chk_a("load_zero", 7'h40, 7'h40, 7'h40, 10'h000);
    press(4'b0010);
    cyc(10);
    press(4'b0010);
    cyc(4);
    chk_a("wrap_down", 7'h10, 7'h10, 7'h10, 10'h002);
    chk_b("wrap_down", 7'h10, 7'h10, 10'h002);
    press(4'b0100);
    cyc(4);
    chk_a("clear", 7'h40, 7'h40, 7'h40, 10'h000);
    chk_b("clear", 7'h40, 7'h40, 10'h000);

    // Hex up from FE: 2-digit instance wraps, 3-digit carries into digit 2.
    sw = {8'hFE, 2'b10};
    press(4'b1000);
    cyc(4);
    chk_a("load_hex", 7'h40, 7'h0E, 7'h06, 10'h000);
    chk_b("load_hex", 7'h0E, 7'h06, 10'h000);
    press(4'b0010);
    cyc(14);
    chk_b("hex_ff", 7'h0E, 7'h0E, 10'h001);
    chk_a("hex_ff", 7'h40, 7'h0E, 7'h0E, 10'h001);
    cyc(7);
    press(4'b0010);
    cyc(2);
    chk_b("hex_wrap", 7'h40, 7'h40, 10'h003);
    chk_a("hex_carry", 7'h79, 7'h40, 7'h40, 10'h001);
    cyc(2);
    chk_b("hex_stop", 7'h40, 7'h40, 10'h002);
    chk_a("hex_stop", 7'h79, 7'h40, 7'h40, 10'h000);

    // Clear and load together: clear wins.
    sw = {8'h37, 2'b00};
    press(4'b1100);
    cyc(4);
    chk_a("clr_load", 7'h40, 7'h40, 7'h40, 10'h000);
    chk_b("clr_load", 7'h40, 7'h40, 10'h000);

    // Run key held 50 cycles toggles once; reset mid-run at count 5.
    sw  = '0;
    key = 4'hD;
    cyc(50);
    key = 4'hF;
    cyc(3);
    chk_a("held_key", 7'h40, 7'h40, 7'h19, 10'h001);
    cyc(3);
    chk_a("count5", 7'h40, 7'h40, 7'h12, 10'h001);
    rst_n = 1'b0;
    cyc(1);
    chk_a("mid_reset", 7'h40, 7'h40, 7'h40, 10'h000);
    check("mid_reset.blank", {a_hex5, a_hex4, a_hex3}, {3{7'h7F}});
    chk_b("mid_reset", 7'h40, 7'h40, 10'h000);
    rst_n = 1'b1;
    cyc(12);
    chk_a("post_reset", 7'h40, 7'h40, 7'h40, 10'h000);

    // Key held through reset release gives no pulse until pressed again.
    rst_n = 1'b0;
    key   = 4'hD;
    cyc(2);
    rst_n = 1'b1;
    cyc(10);
    check("held_thru_reset", a_ledr, 10'h000);
    key = 4'hF;
    cyc(3);
    press(4'b0010);
    cyc(4);
    check("press_after_reset", a_ledr, 10'h001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hex_counter_display.md
# hex_counter_display

Parametrised N-digit counter/timer driving the DE-series seven-segment displays, LEDs, switches and pushbuttons directly, the successor to the single-digit HEX0 top used in the earlier labs. It is instantiated as the board-level design under the DESim testbench or on hardware. It supports 1–6 digits, runtime decimal/hex mode, up/down counting, start/stop, clear and load. All outputs are registered.

## Interface
- DIGITS, 6: active digits (1–6), digit 0 on HEX0; HEX ports beyond DIGITS are blanked.
- CLK_HZ, 50_000_000: CLOCK_50 frequency.
- TICK_HZ, 100: count rate. Prescaler terminal count is CLK_HZ/TICK_HZ − 1, which must be ≥ 1.
- CLOCK_50  in  1  system clock; the only clock. Reset is synchronous and active-low.
- RESETn  in  1  synchronous, active-low reset.
- KEY  in  4  active-low pushbuttons. KEY[1] toggles run/stop, KEY[2] clears, KEY[3] loads, KEY[0] is unused.
- SW  in  10  SW[0] selects direction (0 up, 1 down). SW[1] selects mode (0 decimal, 1 hex). SW[9:2] is the load value.
- HEX0..HEX5  out  7 each  active-low segments, bit6 = g … bit0 = a.
- LEDR  out  10  LEDR[0] = running, LEDR[1] = wrap flag, LEDR[9:2] = 0.

## Operation
- **Key path.** KEY[3:1] each pass through a 2-FF synchroniser, then a falling-edge detect. Each press produces one single-cycle pulse; holding a key gives no further pulses. There is no debounce.
- **Run state.**
  - A run pulse toggles `running`.
  - The prescaler counts only while `running` is set and holds its value while stopped.
  - A tick pulse fires when the prescaler is at terminal count, and the prescaler wraps to 0 on that cycle.
- **Counter.** DIGITS 4-bit digits, with carry/borrow rippling within one cycle.
  - Up, hex: 0xF→0 with carry.
  - Up, decimal: any digit ≥ 9 goes to 0 with carry.
  - Down, hex: 0→0xF with borrow.
  - Down, decimal: 0→9 with borrow; any other value decrements, so digits above 9 left over from hex mode step down to 9.
- **Wrap flag.** Carry out of (or borrow from) the top digit wraps the whole counter and sets the sticky `wrap` flag.
- **Clear.** Counter, prescaler and wrap all go to 0. `running` is unchanged.
- **Load.** SW[9:6] goes to digit 1 and SW[5:2] goes to digit 0, all other digits become 0, wrap is cleared and the prescaler is cleared. Nibbles above 9 load unchanged in decimal mode. When DIGITS = 1, only SW[5:2] loads.
- **Same-cycle priority.** Reset > clear > load > tick. A run-toggle pulse in the same cycle as a tick does not cancel that tick, because the tick derives from the pre-toggle state.
- **Mode and direction.** Changes take effect at the next tick. No remapping of stored digits occurs.
- **Display.** Each active digit decodes from 0–F to active-low segments (0 = 7'h40, F = 7'h0E). Inactive HEX ports hold 7'h7F.

## Timing
- **Reset values.**
  - Counter, prescaler, `running` and `wrap` = 0.
  - Active HEX outputs = 7'h40, inactive = 7'h7F.
  - LEDR = 10'h000.
  - Synchroniser flops = 1 (released key).
- **Key latency.** From the first CLOCK_50 edge sampling KEY low, the press pulse is high during the cycle after the 3rd edge. Its effect on counter or `running` registers at the 4th edge.
- **Display latency.** HEX and LEDR register one edge after the counter/state change.
- **Tick spacing.** While running, ticks are exactly CLK_HZ/TICK_HZ cycles apart. Stop and restart resume the prescaler from its held value.
- **Reset mid-operation.** RESETn low at an edge forces all reset values at that edge, regardless of any pending pulse. A key held through reset release produces no pulse until it is released and pressed again.

## Structure
- Shared package `de_board_pkg` holds:
  - SEG_BLANK = 7'h7F;
  - the 16-entry segment table;
  - the mode constants MODE_DEC/MODE_HEX and DIR_UP/DIR_DOWN;
  - KEY index constants.
- One sub-module, `seg7_decoder` (4-bit in, 7-bit active-low out, combinational), instantiated DIGITS times via generate.
- Key synchroniser, prescaler and counter are inline.

## Test plan
Bench parameters: CLK_HZ = 10, TICK_HZ = 1 (tick every 10 cycles), DIGITS = 3 unless noted.
- **Reset.** Hold RESETn low for 2 cycles → HEX0–HEX2 = 7'h40, HEX3–HEX5 = 7'h7F, LEDR = 0.
- **Decimal up.**
  - Press KEY[1] with SW = 0 → LEDR[0] = 1 four edges after the press.
  - After 10 ticks, HEX1 = 7'h79 (1) and HEX0 = 7'h40 (0).
- **Load and wrap down.**
  - Load with SW[9:2] = 8'h00 in decimal down, then run one tick → HEX2..0 show 9,9,9 and LEDR[1] = 1.
  - A following clear → all 0 and LEDR[1] = 0.
- **Hex mode, full wrap.**
  - With SW[1] = 1, load 8'hFE, then force upper digits via DIGITS = 2. Two ticks → 0x00, wrap set.
  - Decoded F = 7'h0E is seen on the intermediate tick.
- **Same-cycle events.**
  - Clear and load in the same cycle → counter 0.
  - Stop pressed on a tick cycle → that tick is counted, then the counter holds for 30 cycles.
  - Restart → next tick after the remaining prescaler count.
- **Held key and reset mid-run.**
  - KEY[1] held low for 50 cycles → exactly one toggle.
  - RESETn pulsed while running at count 5 → all reset values at the next edge.
